adder_share_arbiter: RTL and testbench

- Shares one nbitripplecarry-style add/sub datapath (a, b, control -> s, cout) among NREQ requesters.
- Round-robin arbitration; valid/ready handshake on each request port and on the single response port.
- Holds operands stable for SETTLE cycles so the ripple chain settles, then captures the result.
- Sits between requesting units (ALU ops, address calc) and the shared adder instance.

---
 rtl/adder_share_arbiter.sv | 163 ++++++++++++++++
 tb/tb_adder_share_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one external ripple add/sub among NREQ requesters; ADDARB_OVF_EN enables signed overflow.
// Latency: grant at T -> rsp_valid at T+SETTLE+1; no grants outside IDLE, response held until rsp_ready.
module adder_share_arbiter #(
   parameter int NREQ   = 4,
   parameter int WIDTH  = 32,
   parameter int SETTLE = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ*WIDTH-1:0]    req_a,
   input  logic [NREQ*WIDTH-1:0]    req_b,
   input  logic [NREQ-1:0]          req_sub,
   output logic [WIDTH-1:0]         adder_a,
   output logic [WIDTH-1:0]         adder_b,
   output logic                     adder_control,
   input  logic [WIDTH-1:0]         adder_s,
   input  logic                     adder_cout,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [$clog2(NREQ)-1:0]  rsp_id,
   output logic [WIDTH-1:0]         rsp_sum,
   output logic                     rsp_cout,
   output logic                     rsp_ovf
);

   localparam int IDW = $clog2(NREQ);
   localparam int CW  = $clog2(SETTLE + 1);

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RESP} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [IDW-1:0]   r_rr_ptr;
   logic [IDW-1:0]   r_id;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_sub;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic [IDW-1:0]   w_gnt;
   logic             w_any;
   logic [IDW:0]     w_idx;
   logic             w_capture;

   // Search starts at the round-robin pointer and wraps modulo NREQ.
   always_comb begin
      w_gnt = '0;
      w_any = 1'b0;
      w_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_idx = {1'b0, r_rr_ptr} + (IDW+1)'(k);
         if (w_idx >= (IDW+1)'(NREQ))
            w_idx = w_idx - (IDW+1)'(NREQ);
         if (!w_any && req_valid[w_idx[IDW-1:0]]) begin
            w_any = 1'b1;
            w_gnt = w_idx[IDW-1:0];
         end
      end
   end

   assign w_capture = (r_state == S_SETTLE) && (r_cnt == CW'(1));

   always_comb begin
      w_state_nxt = r_state;
      req_ready   = '0;
      case (r_state)
         S_IDLE: begin
            if (w_any) begin
               w_state_nxt = S_SETTLE;
               // Gated by rst_n so the grant cannot leak while reset is held.
               if (rst_n)
                  req_ready = NREQ'(1) << w_gnt;
            end
         end
         S_SETTLE: begin
            if (r_cnt == CW'(1))
               w_state_nxt = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready)
               w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_rr_ptr <= '0;
         r_id     <= '0;
         r_cnt    <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_sub    <= 1'b0;
         r_sum    <= '0;
         r_cout   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_a   <= req_a[w_gnt*WIDTH +: WIDTH];
                  r_b   <= req_b[w_gnt*WIDTH +: WIDTH];
                  r_sub <= req_sub[w_gnt];
                  r_id  <= w_gnt;
                  r_cnt <= CW'(SETTLE);
               end
            end
            S_SETTLE: begin
               if (w_capture) begin
                  r_sum  <= adder_s;
                  r_cout <= adder_cout;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            S_RESP: begin
               if (rsp_ready)
                  r_rr_ptr <= (r_id == IDW'(NREQ-1)) ? '0 : r_id + IDW'(1);
            end
            default: ;
         endcase
      end
   end

`ifdef ADDARB_OVF_EN
   logic r_ovf;
   logic w_ovf;

   // Subtract overflows when operand signs differ; add when they match.
   always_comb begin
      w_ovf = 1'b0;
      if (r_sub)
         w_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (adder_s[WIDTH-1] != r_a[WIDTH-1]);
      else
         w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (adder_s[WIDTH-1] != r_a[WIDTH-1]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_ovf <= 1'b0;
      else if (w_capture)
         r_ovf <= w_ovf;
   end

   assign rsp_ovf = r_ovf;
`else
   assign rsp_ovf = 1'b0;
`endif

   assign adder_a       = r_a;
   assign adder_b       = r_b;
   assign adder_control = r_sub;
   assign rsp_valid     = (r_state == S_RESP);
   assign rsp_id        = r_id;
   assign rsp_sum       = r_sum;
   assign rsp_cout      = r_cout;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Randomized bench for adder_share_arbiter with an arithmetic reference model and a stand-in adder.
module tb_adder_share_arbiter;
   localparam int NREQ   = 4;
   localparam int WIDTH  = 32;
   localparam int SETTLE = 2;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic [NREQ-1:0]       req_sub;
   logic [WIDTH-1:0]      adder_a;
   logic [WIDTH-1:0]      adder_b;
   logic                  adder_control;
   logic [WIDTH-1:0]      adder_s;
   logic                  adder_cout;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [1:0]            rsp_id;
   logic [WIDTH-1:0]      rsp_sum;
   logic                  rsp_cout;
   logic                  rsp_ovf;

   int n_tests = 0;
   int n_fail  = 0;
   int ptr     = 0;
   int gnt_cnt [NREQ];

   always #5 clk = ~clk;

   adder_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
      .adder_a(adder_a), .adder_b(adder_b), .adder_control(adder_control),
      .adder_s(adder_s), .adder_cout(adder_cout),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf)
   );

   // Stand-in for the shared ripple adder: subtract is a + ~b + 1.
   assign {adder_cout, adder_s} = adder_control ?
      ({1'b0, adder_a} + {1'b0, ~adder_b} + 33'd1) : ({1'b0, adder_a} + {1'b0, adder_b});

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int model_grant(input logic [NREQ-1:0] mask, input int p);
      for (int k = 0; k < NREQ; k++)
         if (mask[(p + k) % NREQ]) return (p + k) % NREQ;
      return -1;
   endfunction

   task automatic model_result(input logic [31:0] a, input logic [31:0] b, input logic sub,
                               output logic [31:0] s, output logic c, output logic v);
      longint la, lb, sa, sb, r;
      la = a; lb = b;
      sa = $signed(a); sb = $signed(b);
      if (sub) begin
         s = 32'(la - lb);
         c = (la >= lb);
         r = sa - sb;
      end else begin
         s = 32'(la + lb);
         c = ((la + lb) > 64'hFFFF_FFFF);
         r = sa + sb;
      end
`ifdef ADDARB_OVF_EN
      v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
`else
      v = 1'b0;
`endif
   endtask

   task automatic drive_ops(input bit dir, input logic [31:0] da, input logic [31:0] db, input logic dsub);
      for (int i = 0; i < NREQ; i++) begin
         req_a[i*WIDTH +: WIDTH] = dir ? da : $urandom;
         req_b[i*WIDTH +: WIDTH] = dir ? db : $urandom;
         req_sub[i]              = dir ? dsub : 1'($urandom_range(0, 1));
      end
   endtask

   task automatic run_op(input logic [NREQ-1:0] mask, input int stall, input bit dir,
                         input logic [31:0] da, input logic [31:0] db, input logic dsub);
      int g, lat;
      logic [31:0] es;
      logic ec, ev;
      @(negedge clk);
      check_eq("rsp_valid_idle", rsp_valid, 0);
      rsp_ready = 1'b0;
      drive_ops(dir, da, db, dsub);
      req_valid = mask;
      #1;
      g = model_grant(mask, ptr);
      check_eq("req_ready_grant", req_ready, 4'b1 << g);
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) gnt_cnt[i]++;
      model_result(req_a[g*WIDTH +: WIDTH], req_b[g*WIDTH +: WIDTH], req_sub[g], es, ec, ev);
      @(posedge clk);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         drive_ops(1'b0, 0, 0, 1'b0);
         #1;
         check_eq("req_ready_busy", req_ready, 0);
      end while (!rsp_valid && lat < 20);
      check_eq("rsp_latency", lat, SETTLE + 1);
      check_eq("rsp_id", rsp_id, g);
      check_eq("rsp_sum", rsp_sum, es);
      check_eq("rsp_cout", rsp_cout, ec);
      check_eq("rsp_ovf", rsp_ovf, ev);
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         check_eq("stall_valid", rsp_valid, 1);
         check_eq("stall_sum", rsp_sum, es);
         check_eq("stall_ready", req_ready, 0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      ptr = (g + 1) % NREQ;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; req_valid = 4'hF; req_a = '0; req_b = '0; req_sub = '0; rsp_ready = 1'b0;
      foreach (gnt_cnt[i]) gnt_cnt[i] = 0;
      repeat (2) @(negedge clk);
      check_eq("reset_req_ready", req_ready, 0);
      check_eq("reset_rsp_valid", rsp_valid, 0);
      check_eq("reset_adder_a", adder_a, 0);
      rst_n = 1'b1;
      req_valid = '0;
      @(negedge clk); #1;
      check_eq("idle_no_req", req_ready, 0);

      run_op(4'b0001, 0, 1'b1, 32'd13, 32'd12, 1'b0);
      run_op(4'b0100, 0, 1'b1, 32'd13, 32'd12, 1'b1);
      run_op(4'b0100, 0, 1'b1, 32'd12, 32'd13, 1'b1);
      run_op(4'b1111, 5, 1'b0, 0, 0, 1'b0);
      run_op(4'b1111, 0, 1'b0, 0, 0, 1'b0);
      run_op(4'b0001, 0, 1'b1, 32'h7FFF_FFFF, 32'd1, 1'b0);
      run_op(4'b0001, 0, 1'b1, 32'h8000_0000, 32'd1, 1'b1);

      // Reset while an op is settling.
      @(negedge clk);
      rsp_ready = 1'b0;
      drive_ops(1'b1, 32'h1234_5678, 32'h9, 1'b1);
      req_valid = 4'b1000;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_req_ready", req_ready, 0);
      check_eq("mid_rst_rsp_valid", rsp_valid, 0);
      check_eq("mid_rst_adder_a", adder_a, 0);
      check_eq("mid_rst_adder_b", adder_b, 0);
      check_eq("mid_rst_ctrl", adder_control, 0);
      check_eq("mid_rst_rsp_id", rsp_id, 0);
      ptr = 0;
      @(negedge clk);
      rst_n = 1'b1;
      req_valid = '0;
      repeat (4) begin
         @(negedge clk);
         check_eq("post_rst_no_rsp", rsp_valid, 0);
      end

      foreach (gnt_cnt[i]) gnt_cnt[i] = 0;
      for (int n = 0; n < NREQ; n++) run_op(4'hF, 0, 1'b0, 0, 0, 1'b0);
      for (int i = 0; i < NREQ; i++) check_eq("fair_pulses", gnt_cnt[i], 1);
      run_op(4'hF, 0, 1'b0, 0, 0, 1'b0);

      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 7) == 0) begin
            @(negedge clk);
            req_valid = '0;
            #1;
            check_eq("idle_gap_ready", req_ready, 0);
         end
         run_op(4'($urandom_range(1, 15)), $urandom_range(0, 3), 1'b0, 0, 0, 1'b0);
      end

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
